// File: rtl/btn_evt_pkg.sv
// Shared state encoding and default timing for the button event decoder.
// Latency: n/a (types and constants only). Backpressure: none.
package btn_evt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } btn_evt_state_t;

    localparam int BTN_LONG_CYCLES   = 50_000_000;
    localparam int BTN_DCLICK_CYCLES = 15_000_000;
    localparam int BTN_REPEAT_CYCLES = 10_000_000;
    localparam int BTN_CNT_W         = 26;

endpackage

// File: rtl/btn_evt_timer.sv
// Free-running cycle counter with clear, enable and a terminal-count compare.
// Latency: tc is combinational on the registered count. Backpressure: none.
module btn_evt_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into click / double-click / long-press pulses.
// Latency: pulses registered one clock after the deciding sample. Backpressure: none.
// BTN_EVT_REPEAT_EN adds a periodic repeat_o pulse while the button is long-held.
module btn_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int LONG_CYCLES   = BTN_LONG_CYCLES,
    parameter int DCLICK_CYCLES = BTN_DCLICK_CYCLES,
    parameter int REPEAT_CYCLES = BTN_REPEAT_CYCLES,
    parameter int CNT_W         = BTN_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_level,
    output logic click_o,
    output logic dclick_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int MAX_CYC = (LONG_CYCLES > DCLICK_CYCLES) ?
        ((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES) :
        ((DCLICK_CYCLES > REPEAT_CYCLES) ? DCLICK_CYCLES : REPEAT_CYCLES);

    if ((64'd1 << CNT_W) < 64'(MAX_CYC)) begin : g_cnt_w_check
        $error("CNT_W too narrow for the configured cycle counts");
    end

    btn_evt_state_t   state;
    logic             btn_prev;
    logic             rise, fall, tc, state_chg;
    logic [CNT_W-1:0] term;

    assign rise = btn_level & ~btn_prev;
    assign fall = ~btn_level & btn_prev;
    assign term = (state == ST_PRESS1) ? CNT_W'(LONG_CYCLES - 1) : CNT_W'(DCLICK_CYCLES - 1);

    // Mirrors the transition conditions below so the timer restarts on every state change.
    always_comb begin
        state_chg = 1'b0;
        case (state)
            ST_IDLE:   state_chg = rise;
            ST_PRESS1: state_chg = fall | (tc & btn_level);
            ST_WAIT2:  state_chg = rise | tc;
            ST_PRESS2: state_chg = fall;
            ST_LONG:   state_chg = fall;
            default:   state_chg = 1'b1;
        endcase
    end

    btn_evt_timer #(.CNT_W(CNT_W)) u_main_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state_chg),
        .en      (1'b1),
        .term    (term),
        .tc      (tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            btn_prev <= 1'b1;
            click_o  <= 1'b0;
            dclick_o <= 1'b0;
            long_o   <= 1'b0;
            held_o   <= 1'b0;
        end else begin
            btn_prev <= btn_level;
            click_o  <= 1'b0;
            dclick_o <= 1'b0;
            long_o   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state  <= ST_PRESS1;
                        held_o <= 1'b1;
                    end
                end
                ST_PRESS1: begin
                    // A release on the threshold cycle is still a short press.
                    if (fall) begin
                        state  <= ST_WAIT2;
                        held_o <= 1'b0;
                    end else if (tc && btn_level) begin
                        state  <= ST_LONG;
                        long_o <= 1'b1;
                    end
                end
                ST_WAIT2: begin
                    if (rise) begin
                        state    <= ST_PRESS2;
                        dclick_o <= 1'b1;
                        held_o   <= 1'b1;
                    end else if (tc) begin
                        state   <= ST_IDLE;
                        click_o <= 1'b1;
                    end
                end
                ST_PRESS2, ST_LONG: begin
                    if (fall) begin
                        state  <= ST_IDLE;
                        held_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    held_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef BTN_EVT_REPEAT_EN
    logic rep_tc;

    btn_evt_timer #(.CNT_W(CNT_W)) u_rep_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     ((state != ST_LONG) | rep_tc),
        .en      (1'b1),
        .term    (CNT_W'(REPEAT_CYCLES - 1)),
        .tc      (rep_tc)
    );

    // Gated by the live level so a release on a repeat boundary emits nothing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            repeat_o <= 1'b0;
        end else begin
            repeat_o <= (state == ST_LONG) && btn_level && rep_tc;
        end
    end
`else
    assign repeat_o = 1'b0;
`endif

endmodule
